ext_int_ctrl: RTL and testbench
===============================

// Module: ext_int_ctrl
// PURPOSE
//  Upstream interrupt front-end for the CPU program counter stage. Takes 4 raw asynchronous
//  external interrupt requests, synchronises and edge-detects them, applies a mask, and
//  queues events in saturating per-source pending counters.
//  Replays queued events as clean, gap-separated pulses on ext_int[3:0]
//  (bit i drives ext_int(i+1) of the PC stage), so every event is seen as a distinct rising edge.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth per source (>=2)
//  PULSE_LEN    2  cycles ext_int[i] is held high per event (>=1)
//  GAP_LEN      2  cycles ext_int[i] is forced low after each pulse (>=1)
//  CNT_W        2  pending counter width; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  irq_in     in   4  raw asynchronous interrupt requests, rising-edge significant
//  bus_we     in   1  register write strobe
//  bus_addr   in   2  register select
//  bus_wdata  in   8  write data
//  bus_rdata  out  8  read data, registered, valid 1 cycle after bus_addr is presented
//  ext_int    out  4  pulsed interrupt lines to the PC stage
//  pending    out  4  bit i = pending counter i non-zero
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  Reset state: ext_int=0, pending=0, bus_rdata=0, mask=4'hF (all enabled), overflow=0,
//   all FSMs IDLE, sync flops 0.
//  Arming: event detection is suppressed for SYNC_STAGES+1 cycles after reset deasserts,
//   so a line held high across reset yields no event.
//  Detect: event[i] = synced[i] & ~synced_prev[i] & mask[i] & armed.
//  Latency: irq_in rising before edge k -> ext_int[i] high after edge k+SYNC_STAGES+1 (default k+3).
//   This applies when source i is IDLE with zero pending; the event bypasses the counter.
//  Per-source FSM:
//   IDLE: if pending_cnt>0 or event -> HIGH, load PULSE_LEN. If entered from pending,
//    decrement the counter; the event increments it, and both in the same cycle leave it unchanged.
//   HIGH: ext_int[i]=1; count down; at expiry -> GAP, load GAP_LEN.
//   GAP: ext_int[i]=0; count down; at expiry -> IDLE.
//   Pulse period is PULSE_LEN+GAP_LEN cycles; back-to-back queued events produce back-to-back periods.
//  Counter: an event during HIGH/GAP, or while the counter is non-zero, increments pending_cnt[i].
//   At saturation the event is dropped and overflow[i] is set (sticky).
//  Mask: clearing mask[i] blocks new events only. An in-flight pulse and queued counts still drain.
//   Setting mask[i] does not create an event for a line that is already high.
//  Registers (write takes effect at the edge with bus_we=1):
//   addr0 mask       RW  [3:0]; [7:4] read 0
//   addr1 pending    R: [3:0]=pending; W1C: writing 1 to bit i zeroes pending_cnt[i].
//    Clear beats a same-cycle increment; an in-flight pulse completes.
//   addr2 overflow   R: [3:0]; W1C; a same-cycle set beats the clear.
//   addr3 stats      see CONFIGURATION
//  Reset mid-operation: ext_int drops at the reset edge, queued events are discarded,
//   and the arming window applies again.
// CONFIGURATION
//  Macro EXT_INT_STATS_EN:
//   Defined: four 8-bit saturating counters count detected (unmasked) events, including dropped ones.
//    Writing addr3 sets select=wdata[1:0]; reading addr3 returns the selected counter.
//    Counters and select reset to 0; writing addr3 with wdata[7]=1 also zeroes the selected counter.
//   Undefined: no counters are synthesised; addr3 reads 0 and writes are ignored.
// TESTING
//  1 reset, irq_in[0] 0->1 before edge 10 -> ext_int[0]=1 after edges 13..14, 0 for >=2 cycles, pending=0.
//  2 mask=4'hF, three irq_in[1] edges 2 cycles apart -> exactly 3 ext_int[1] pulses, 4 cycles apart; pending[1] clears after the 3rd pulse starts.
//  3 six irq_in[2] edges while busy (CNT_W=2) -> 4 pulses total; addr2 reads 8'h04; W1C addr2 with 8'h04 -> reads 0.
//  4 mask=4'hE, toggle irq_in[0] -> no pulse; then write mask=4'hF with irq_in[0] held high -> no pulse.
//  5 queue 2 events on source 3, W1C addr1 with 8'h08 in the same cycle as a new event -> pending[3]=0; only the in-flight pulse completes.
//  6 reset asserted during HIGH with irq_in[0] held high -> ext_int=0 at the reset edge; no pulse after reset. With EXT_INT_STATS_EN, 5 edges on source 1 -> addr3 select 1 reads 8'h05.

Source files
------------

// File: rtl/ext_int_ctrl.sv
// rtl/ext_int_ctrl.sv - external interrupt front-end: sync, edge detect, mask, queue, pulse replay
//
// Purpose:
//   Four raw asynchronous interrupt lines are synchronised and edge-detected.
//   Each detected edge passes through a mask and is counted in a saturating
//   per-source pending counter. The events are then replayed on ext_int as
//   gap-separated pulses, so the PC stage sees every event as its own rising edge.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   irq_in     in   4  raw asynchronous interrupt requests (rising edge significant)
//   bus_we     in   1  register write strobe
//   bus_addr   in   2  register select (0 mask, 1 pending, 2 overflow, 3 stats)
//   bus_wdata  in   8  write data
//   bus_rdata  out  8  registered read data, valid one cycle after bus_addr
//   ext_int    out  4  pulsed interrupt lines to the PC stage
//   pending    out  4  bit i set while pending counter i is non-zero
//
// Optional feature macro: EXT_INT_STATS_EN (per-source 8-bit event counters on addr3)

module ext_int_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 2,
    parameter int GAP_LEN     = 2,
    parameter int CNT_W       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_in,
    input  logic       bus_we,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic [3:0] ext_int,
    output logic [3:0] pending
);

    localparam int MAXLEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW     = ($clog2(MAXLEN) < 1) ? 1 : $clog2(MAXLEN);
    localparam int AW     = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [3:0]    synced;
    logic [3:0]    synced_prev;
    logic [3:0]    evt_q;
    logic [3:0]    mask_q;
    logic [3:0]    overflow;
    logic [3:0]    pend_clr;
    logic [3:0]    ovf_clr;
    logic [AW-1:0] arm_cnt;
    logic          armed;
    logic [7:0]    stats_rd;
    logic          unused_wdata;

    // The arming window covers the time the synchronisers need to fill after
    // reset, so a line that was already high never looks like a fresh edge.
    assign armed = (arm_cnt == AW'(SYNC_STAGES + 1));

    assign pend_clr = (bus_we && bus_addr == 2'd1) ? bus_wdata[3:0] : 4'h0;
    assign ovf_clr  = (bus_we && bus_addr == 2'd2) ? bus_wdata[3:0] : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt     <= '0;
            synced_prev <= 4'h0;
            evt_q       <= 4'h0;
            mask_q      <= 4'hF;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + AW'(1);
            end
            synced_prev <= synced;
            // Registered detect adds the cycle that puts ext_int at k+SYNC_STAGES+1.
            evt_q       <= synced & ~synced_prev & mask_q & {4{armed}};
            if (bus_we && bus_addr == 2'd0) begin
                mask_q <= bus_wdata[3:0];
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_src
        logic [SYNC_STAGES-1:0] sync_q;
        state_t                 state_q, state_d;
        logic [TW-1:0]          tmr_q, tmr_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   ovf_q, ovf_set;
        logic                   start, take, inc;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in[i]};
            end
        end

        assign synced[i] = sync_q[SYNC_STAGES-1];

        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            start   = 1'b0;
            case (state_q)
                IDLE: start = (cnt_q != '0) || evt_q[i];
                HIGH: begin
                    if (tmr_q == '0) begin
                        state_d = GAP;
                        tmr_d   = TW'(GAP_LEN - 1);
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                GAP: begin
                    // Chaining straight into the next pulse keeps queued
                    // events at exactly PULSE_LEN+GAP_LEN cycles apart.
                    if (tmr_q == '0) begin
                        start = (cnt_q != '0) || evt_q[i];
                        if (!start) begin
                            state_d = IDLE;
                        end
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (start) begin
                state_d = HIGH;
                tmr_d   = TW'(PULSE_LEN - 1);
            end

            // A start with an empty counter consumes the event directly;
            // otherwise the event joins the queue behind older entries.
            take    = start && (cnt_q != '0);
            inc     = evt_q[i] && !(start && (cnt_q == '0));
            cnt_d   = cnt_q;
            ovf_set = 1'b0;
            if (inc && !take) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (take && !inc) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (pend_clr[i]) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                tmr_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                tmr_q   <= tmr_d;
                cnt_q   <= cnt_d;
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        assign ext_int[i]  = (state_q == HIGH);
        assign pending[i]  = (cnt_q != '0);
        assign overflow[i] = ovf_q;
    end

`ifdef EXT_INT_STATS_EN
    logic [7:0] stat_q [4];
    logic [1:0] sel_q;
    logic       stat_wr;

    assign stat_wr = bus_we && (bus_addr == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                stat_q[i] <= 8'h00;
            end
        end else begin
            if (stat_wr) begin
                sel_q <= bus_wdata[1:0];
            end
            for (int i = 0; i < 4; i++) begin
                if (stat_wr && bus_wdata[7] && (bus_wdata[1:0] == 2'(i))) begin
                    stat_q[i] <= 8'h00;
                end else if (evt_q[i] && (stat_q[i] != 8'hFF)) begin
                    stat_q[i] <= stat_q[i] + 8'd1;
                end
            end
        end
    end

    assign stats_rd     = stat_q[sel_q];
    assign unused_wdata = ^bus_wdata[6:4];
`else
    assign stats_rd     = 8'h00;
    assign unused_wdata = ^bus_wdata[7:4];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata <= 8'h00;
        end else begin
            case (bus_addr)
                2'd0:    bus_rdata <= {4'h0, mask_q};
                2'd1:    bus_rdata <= {4'h0, pending};
                2'd2:    bus_rdata <= {4'h0, overflow};
                default: bus_rdata <= stats_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb/tb_ext_int_ctrl.sv - directed self-checking bench for ext_int_ctrl

module tb_ext_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       bus_we;
    logic [1:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic [3:0] ext_int;
    logic [3:0] pending;

    int n_cmp  = 0;
    int n_fail = 0;
    int rises [4] = '{0, 0, 0, 0};
    logic [3:0] ext_prev = 4'h0;

    ext_int_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .ext_int   (ext_int),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Rising edges seen on each ext_int line, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ext_int[i] === 1'b1 && ext_prev[i] !== 1'b1) begin
                rises[i]++;
            end
        end
        ext_prev <= ext_int;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        tick();
        bus_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        bus_addr = a;
        tick();
    endtask

    initial begin
        logic [15:0] irq_pat, ext_pat, pend_pat;
        logic [31:0] pat5;
        int r0;

        reset     = 1'b1;
        irq_in    = 4'h0;
        bus_we    = 1'b0;
        bus_addr  = 2'd0;
        bus_wdata = 8'h00;

        // Reset state
        ticks(3);
        check("rst_ext_int", 32'(ext_int), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_rdata", 32'(bus_rdata), 32'h0);
        reset = 1'b0;
        rd(2'd0);
        check("rst_mask", 32'(bus_rdata), 32'h0F);
        ticks(5);

        // 1: single event, bypass latency k+3, PULSE_LEN high then gap
        irq_in[0] = 1'b1;
        ext_pat   = 16'h0018;
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("t1_ext_j%0d", j), 32'(ext_int), 32'(ext_pat[j]));
        end
        check("t1_pending", 32'(pending), 32'h0);
        check("t1_rises", 32'(rises[0]), 32'd1);
        irq_in[0] = 1'b0;
        ticks(6);

        // 2: three edges two cycles apart on source 1
        irq_pat  = 16'h0015;
        ext_pat  = 16'h1998;
        pend_pat = 16'h07E0;
        for (int j = 0; j < 16; j++) begin
            irq_in[1] = irq_pat[j];
            tick();
            check($sformatf("t2_ext_j%0d", j), 32'(ext_int[1]), 32'(ext_pat[j]));
            check($sformatf("t2_pend_j%0d", j), 32'(pending[1]), 32'(pend_pat[j]));
        end
        check("t2_rises", 32'(rises[1]), 32'd3);
        ticks(4);

        // 3: ten edges on source 2 saturate the queue; two are dropped
        r0 = rises[2];
        for (int j = 0; j < 40; j++) begin
            irq_in[2] = (j < 20) && (j % 2 == 0);
            tick();
            if (j == 17) begin
                check("t3_pend_full", 32'(pending[2]), 32'h1);
            end
        end
        check("t3_rises", 32'(rises[2] - r0), 32'd8);
        check("t3_pend_drained", 32'(pending), 32'h0);
        rd(2'd2);
        check("t3_ovf", 32'(bus_rdata), 32'h04);
        wr(2'd2, 8'h04);
        rd(2'd2);
        check("t3_ovf_clr", 32'(bus_rdata), 32'h00);

        // 4: masked source, then unmasking with the line already high
        wr(2'd0, 8'h0E);
        rd(2'd0);
        check("t4_mask_rd", 32'(bus_rdata), 32'h0E);
        r0 = rises[0];
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        ticks(6);
        check("t4_masked_rises", 32'(rises[0] - r0), 32'd0);
        check("t4_masked_pend", 32'(pending), 32'h0);
        irq_in[0] = 1'b1;
        ticks(5);
        wr(2'd0, 8'hFF);
        ticks(8);
        check("t4_unmask_rises", 32'(rises[0] - r0), 32'd0);
        check("t4_unmask_ext", 32'(ext_int), 32'h0);
        rd(2'd0);
        check("t4_mask_hi_zero", 32'(bus_rdata), 32'h0F);
        irq_in[0] = 1'b0;
        ticks(4);

        // 5: two queued on source 3, W1C collides with a new event
        r0   = rises[3];
        pat5 = 32'h0000_0255;
        bus_addr  = 2'd1;
        bus_wdata = 8'h08;
        for (int j = 0; j < 25; j++) begin
            irq_in[3] = pat5[j];
            bus_we    = (j == 12);
            tick();
            if (j == 11) begin
                check("t5_pend_before", 32'(pending[3]), 32'h1);
            end
            if (j == 12) begin
                check("t5_pend_cleared", 32'(pending[3]), 32'h0);
                check("t5_inflight", 32'(ext_int[3]), 32'h1);
            end
        end
        bus_we = 1'b0;
        check("t5_rises", 32'(rises[3] - r0), 32'd3);
        check("t5_pend_end", 32'(pending), 32'h0);

        // 6: reset during HIGH with the line held high
        irq_in[0] = 1'b1;
        ticks(4);
        check("t6_high", 32'(ext_int[0]), 32'h1);
        reset = 1'b1;
        tick();
        check("t6_rst_ext", 32'(ext_int), 32'h0);
        check("t6_rst_pend", 32'(pending), 32'h0);
        r0 = rises[0];
        tick();
        reset = 1'b0;
        ticks(12);
        check("t6_no_rearm", 32'(rises[0] - r0), 32'd0);
        irq_in[0] = 1'b0;
        ticks(4);

        // Statistics on source 1: five edges
        for (int j = 0; j < 40; j++) begin
            irq_in[1] = (j < 10) && (j % 2 == 0);
            tick();
        end
        wr(2'd3, 8'h01);
        rd(2'd3);
`ifdef EXT_INT_STATS_EN
        check("stats_sel1", 32'(bus_rdata), 32'h05);
`else
        check("stats_absent", 32'(bus_rdata), 32'h00);
`endif
        wr(2'd3, 8'h81);
        rd(2'd3);
        check("stats_clr", 32'(bus_rdata), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
